// File: rtl/alu_sequencer.sv
// Sequences commands from two round-robin arbitrated requesters into an ALU via
// per-register load enables. Optional ALU_SEQ_OP_REUSE_EN skips LOAD_OP on a repeated opcode.
module alu_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req_valid,
  input  logic [2*NB_DATA-1:0] i_req_a,
  input  logic [2*NB_DATA-1:0] i_req_b,
  input  logic [2*NB_OP-1:0]   i_req_op,
  output logic [1:0]           o_req_ready,
  output logic [NB_DATA-1:0]   o_alu_data_a,
  output logic [NB_DATA-1:0]   o_alu_data_b,
  output logic [NB_OP-1:0]     o_alu_op,
  output logic                 o_en_A,
  output logic                 o_en_B,
  output logic                 o_en_OP,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_alu_zero,
  input  logic                 i_alu_overflow,
  output logic                 o_rsp_valid,
  output logic                 o_rsp_id,
  output logic [NB_DATA-1:0]   o_rsp_result,
  output logic                 o_rsp_zero,
  output logic                 o_rsp_overflow,
  input  logic                 i_rsp_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    WAIT    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [NB_DATA-1:0]   cmd_a;
  logic [NB_DATA-1:0]   cmd_b;
  logic [NB_OP-1:0]     cmd_op;
  logic                 cmd_id;
  logic                 prio;
  logic                 win_id;
  logic                 accept;
  logic                 skip_op;

  // On a tie, prio names the requester that was not granted last.
  always_comb begin
    if (i_req_valid == 2'b11) win_id = prio;
    else                      win_id = i_req_valid[1];
  end

  assign accept = (state == IDLE) && (|i_req_valid);

`ifdef ALU_SEQ_OP_REUSE_EN
  logic [NB_OP-1:0] last_op;
  logic             last_op_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_op     <= '0;
      last_op_vld <= 1'b0;
    end else if (state == LOAD_OP) begin
      last_op     <= cmd_op;
      last_op_vld <= 1'b1;
    end
  end

  assign skip_op = last_op_vld && (cmd_op == last_op);
`else
  assign skip_op = 1'b0;
`endif

  // NOTE: state is updated with <= so every reader in this cycle sees the old value.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = skip_op ? WAIT : LOAD_OP;
      LOAD_OP: state_next = WAIT;
      WAIT:    state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_a          <= '0;
      cmd_b          <= '0;
      cmd_op         <= '0;
      cmd_id         <= 1'b0;
      prio           <= 1'b0;
      o_rsp_id       <= 1'b0;
      o_rsp_result   <= '0;
      o_rsp_zero     <= 1'b0;
      o_rsp_overflow <= 1'b0;
    end else begin
      if (accept) begin
        cmd_a  <= i_req_a[win_id*NB_DATA +: NB_DATA];
        cmd_b  <= i_req_b[win_id*NB_DATA +: NB_DATA];
        cmd_op <= i_req_op[win_id*NB_OP +: NB_OP];
        cmd_id <= win_id;
        prio   <= ~win_id;
      end
      if (state == WAIT) begin
        o_rsp_id       <= cmd_id;
        o_rsp_result   <= i_alu_result;
        o_rsp_zero     <= i_alu_zero;
        o_rsp_overflow <= i_alu_overflow;
      end
    end
  end

  assign o_alu_data_a = cmd_a;
  assign o_alu_data_b = cmd_b;
  assign o_alu_op     = cmd_op;

  always_comb begin
    o_req_ready = 2'b00;
    o_en_A      = 1'b0;
    o_en_B      = 1'b0;
    o_en_OP     = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (state)
      IDLE:    if (accept) o_req_ready = win_id ? 2'b10 : 2'b01;
      LOAD_A:  o_en_A = 1'b1;
      LOAD_B:  o_en_B = 1'b1;
      LOAD_OP: o_en_OP = 1'b1;
      WAIT:    ;
      RESP:    o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a small registered ALU model closes the loop,
// directed commands push expected responses, a monitor pops and compares them.
module tb_alu_sequencer;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
`ifdef ALU_SEQ_OP_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    logic       z;
    logic       o;
  } cmd_t;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       z;
    logic       o;
    int         acc_cyc;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [11:0] req_op = '0;
  logic [1:0]  req_ready;
  logic [7:0]  alu_data_a, alu_data_b;
  logic [5:0]  alu_op;
  logic        en_a, en_b, en_op;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_overflow;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_overflow;
  logic [7:0]  rsp_result;
  logic        rsp_ready = 1'b1;

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   en_op_cnt = 0;
  exp_t sb[$];
  cmd_t q0[$];
  cmd_t q1[$];
  logic [5:0] m_last = '0;
  bit         m_flag = 1'b0;

  alu_sequencer dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
    .o_req_ready(req_ready),
    .o_alu_data_a(alu_data_a), .o_alu_data_b(alu_data_b), .o_alu_op(alu_op),
    .o_en_A(en_a), .o_en_B(en_b), .o_en_OP(en_op),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero), .i_alu_overflow(alu_overflow),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
    .o_rsp_zero(rsp_zero), .o_rsp_overflow(rsp_overflow), .i_rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Registered ALU: operand/op registers loaded by the enables, combinational result.
  logic [7:0] ra = '0, rb = '0;
  logic [5:0] rop = '0;
  logic [8:0] sum;
  always @(posedge clk) begin
    if (en_a)  ra  <= alu_data_a;
    if (en_b)  rb  <= alu_data_b;
    if (en_op) rop <= alu_op;
  end
  always_comb begin
    sum = {1'b0, ra & rb};
    if (rop == OP_ADD) sum = {1'b0, ra} + {1'b0, rb};
    if (rop == OP_SUB) sum = {1'b0, ra} - {1'b0, rb};
  end
  assign alu_result   = sum[7:0];
  assign alu_zero     = (sum[7:0] == 8'h00);
  assign alu_overflow = sum[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_lat(input logic [5:0] op, output int lat);
    if (REUSE && m_flag && op == m_last) begin
      lat = 4;
    end else begin
      lat = 5;
      m_last = op;
      m_flag = 1'b1;
    end
  endtask

  // Monitor: latency on the rising edge of valid, payload on the handshake.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (en_op) en_op_cnt++;
      if (rsp_valid && sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rsp: o_rsp_valid=1 with no outstanding command (cycle %0d)", cyc);
      end else if (rsp_valid) begin
        if (!prev_valid) check("rsp_latency", cyc - sb[0].acc_cyc, sb[0].lat);
        if (rsp_ready) begin
          check("rsp_id", rsp_id, sb[0].id);
          check("rsp_result", rsp_result, sb[0].res);
          check("rsp_flags", {rsp_zero, rsp_overflow}, {sb[0].z, sb[0].o});
          void'(sb.pop_front());
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // Presents queued commands on both requesters until all are accepted; order holds the expected grants.
  task automatic drive_reqs(input logic [7:0] order, input int n, output int last_acc);
    int   guard = 0;
    int   idx = 0;
    cmd_t c;
    exp_t e;
    last_acc = -1;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 100) begin
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0);
      if (q0.size() > 0) begin req_a[7:0] = q0[0].a; req_b[7:0] = q0[0].b; req_op[5:0] = q0[0].op; end
      if (q1.size() > 0) begin req_a[15:8] = q1[0].a; req_b[15:8] = q1[0].b; req_op[11:6] = q1[0].op; end
      @(negedge clk);
      guard++;
      if (req_ready != 2'b00) begin
        int k;
        k = req_ready[1] ? 1 : 0;
        if (idx < n) check("grant_order", k, {31'd0, order[idx]});
        idx++;
        c = (k == 1) ? q1.pop_front() : q0.pop_front();
        e.id = k[0]; e.res = c.res; e.z = c.z; e.o = c.o; e.acc_cyc = cyc;
        model_lat(c.op, e.lat);
        sb.push_back(e);
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    if (guard >= 100) check("accept_timeout", 1, 0);
    check("grant_count", idx, n);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() > 0 && g < 60) begin @(negedge clk); g++; end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, hs, g, cnt, base;
    logic [10:0] snap;
    logic [2:0] en_seq [4];
    en_seq = '{3'b100, 3'b010, 3'b001, 3'b000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_enables", {en_a, en_b, en_op}, 3'b000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", {rsp_id, rsp_result, rsp_zero, rsp_overflow}, 11'd0);
    check("rst_alu_bus", {alu_data_a, alu_data_b, alu_op}, 22'd0);
    @(posedge clk); #1;

    // ADD 0xFF+0x01 from req0: enables on consecutive cycles, result 0 with carry
    q0.push_back('{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1});
    drive_reqs(8'b0, 1, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("enables_cyc%0d", i + 1), {en_a, en_b, en_op}, en_seq[i]);
      if (i == 0) check("alu_bus", {alu_data_a, alu_data_b, alu_op}, {8'hFF, 8'h01, OP_ADD});
    end
    wait_drain();

    // Response back-pressure: 10 stalled cycles, then accept right after the handshake
    rsp_ready = 1'b0;
    q1.push_back('{8'h0F, 8'h01, OP_ADD, 8'h10, 1'b0, 1'b0});
    drive_reqs(8'b1, 1, acc);
    req_valid = 2'b10;
    req_a[15:8] = 8'h01; req_b[15:8] = 8'h02; req_op[11:6] = OP_SUB;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    check("stall_rsp_seen", rsp_valid, 1'b1);
    snap = {rsp_id, rsp_result, rsp_zero, rsp_overflow};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_rsp_stable", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow}, {1'b1, snap});
      check("stall_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    @(posedge clk); #1;
    q1.push_back('{8'h01, 8'h02, OP_SUB, 8'hFF, 1'b0, 1'b1});
    drive_reqs(8'b1, 1, acc);
    check("accept_after_handshake", acc, hs + 1);
    wait_drain();

    // Both requesters valid every cycle: grants alternate 0,1,0,1
    q0.push_back('{8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b0});
    q1.push_back('{8'h50, 8'h60, OP_SUB, 8'hF0, 1'b0, 1'b1});
    q0.push_back('{8'h80, 8'h80, OP_ADD, 8'h00, 1'b1, 1'b1});
    q1.push_back('{8'h33, 8'h11, OP_SUB, 8'h22, 1'b0, 1'b0});
    drive_reqs(8'b1010, 4, acc);
    wait_drain();

    // Reset during LOAD_B aborts the command; pointer returns to requester 0
    req_valid = 2'b01;
    req_a[7:0] = 8'h01; req_b[7:0] = 8'h01; req_op[5:0] = OP_ADD;
    @(negedge clk);
    check("abort_grant", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_in_load_b", en_b, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    m_flag = 1'b0;
    @(negedge clk);
    check("abort_enables", {en_a, en_b, en_op}, 3'b000);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) cnt++;
      @(negedge clk);
    end
    check("abort_no_rsp", cnt, 0);
    @(posedge clk); #1;

    // Tie after reset goes to req0; back-to-back SUB exercises op reuse when enabled
    base = en_op_cnt;
    q0.push_back('{8'h10, 8'h03, OP_SUB, 8'h0D, 1'b0, 1'b0});
    q1.push_back('{8'h05, 8'h05, OP_SUB, 8'h00, 1'b1, 1'b0});
    drive_reqs(8'b10, 2, acc);
    wait_drain();
    check("en_op_pulses", en_op_cnt - base, REUSE ? 1 : 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (errors=%0d)", n_err);
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NB_DATA, 8, operand/result width
- NB_OP, 6, opcode width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, single clock, rising edge
- i_rst, in, 1, synchronous active-high reset
- i_req_valid, in, 2, per-requester command valid
- i_req_a, in, 2*NB_DATA, operand A per requester; requester k at bits [k*NB_DATA +: NB_DATA]
- i_req_b, in, 2*NB_DATA, operand B per requester; same packing as i_req_a
- i_req_op, in, 2*NB_OP, opcode per requester; requester k at bits [k*NB_OP +: NB_OP]
- o_req_ready, out, 2, per-requester accept
- o_alu_data_a, out, NB_DATA, operand A bus to the ALU top
- o_alu_data_b, out, NB_DATA, operand B bus to the ALU top
- o_alu_op, out, NB_OP, opcode bus to the ALU top
- o_en_A, out, 1, ALU A-register load enable
- o_en_B, out, 1, ALU B-register load enable
- o_en_OP, out, 1, ALU OP-register load enable
- i_alu_result, in, NB_DATA, ALU result
- i_alu_zero, in, 1, ALU zero flag
- i_alu_overflow, in, 1, ALU carry/overflow flag
- o_rsp_valid, out, 1, response valid
- o_rsp_id, out, 1, index of the requester that issued the command
- o_rsp_result, out, NB_DATA, captured result
- o_rsp_zero, out, 1, captured zero flag
- o_rsp_overflow, out, 1, captured overflow flag
- i_rsp_ready, in, 1, response consumer ready
REQ-003 Clock is i_clk only; reset is i_rst, synchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, LOAD_A, LOAD_B, LOAD_OP, WAIT, RESP.
REQ-005 In IDLE, o_req_ready SHALL be one-hot to the arbitration winner when any i_req_valid bit is set, else 0; o_req_ready SHALL be 0 in every other state.
REQ-006 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-007 On accept (valid & ready), the block SHALL latch a, b, op and id, then go to LOAD_A.
REQ-008 o_alu_data_a, o_alu_data_b and o_alu_op SHALL drive the latched command continuously.
REQ-009 Enables SHALL be one-hot by state: o_en_A only in LOAD_A, o_en_B only in LOAD_B, o_en_OP only in LOAD_OP; none in IDLE, WAIT or RESP.
REQ-010 Transitions SHALL be LOAD_A->LOAD_B->LOAD_OP->WAIT->RESP, one cycle each.
REQ-011 On the WAIT->RESP edge, i_alu_result, i_alu_zero and i_alu_overflow SHALL be registered into the o_rsp_* outputs, and o_rsp_valid SHALL rise 5 cycles after the accept edge.
REQ-012 In RESP, o_rsp_valid and the response data SHALL hold stable until i_rsp_ready=1; the block SHALL then go to IDLE with o_rsp_valid=0 the next cycle.
REQ-013 A requester that deasserts i_req_valid before accept SHALL lose nothing; commands are never dropped after accept.

Reset
REQ-014 Reset SHALL force: state IDLE, o_req_ready=0, enables=0, o_rsp_valid=0, o_rsp_* data=0, o_rsp_id=0, ALU buses=0, round-robin pointer favouring requester 0, op-reuse flag cleared.
REQ-015 Reset in any state SHALL abort the command in flight; no response SHALL be issued for it.

Configuration
REQ-016 Macro ALU_SEQ_OP_REUSE_EN: when defined, the block SHALL track the last opcode loaded via o_en_OP, and a command whose op equals it (flag set) SHALL skip LOAD_OP (LOAD_B->WAIT, o_rsp_valid 4 cycles after accept).
REQ-017 When ALU_SEQ_OP_REUSE_EN is undefined, LOAD_OP SHALL always execute and latency SHALL always be 5.

Verification
REQ-018 Req0 ADD a=0xFF b=0x01 -> en_A, en_B, en_OP pulses on consecutive cycles; rsp result=0x00 zero=1 overflow=1 id=0 at accept+5.
REQ-019 Both valid every cycle, 4 commands -> grant order 0,1,0,1.
REQ-020 i_rsp_ready held 0 for 10 cycles -> response stable, o_req_ready=0 throughout; accept resumes the cycle after handshake+1.
REQ-021 i_rst pulsed in LOAD_B -> enables 0 next cycle, no o_rsp_valid, next tie grants req0.
REQ-022 With ALU_SEQ_OP_REUSE_EN: two consecutive SUB commands (0x10-0x03, then 0x05-0x05) -> second has no en_OP pulse, results 0x0D then 0x00 with zero=1 at accept+4; without the macro both take 5 cycles.
